// File: rtl/qif_pkg.sv
// Shared types, defaults and the QIF membrane update function for the neuron array.
package qif_pkg;

  localparam int V_W   = 8;
  localparam int ACC_W = 10;

  typedef logic signed [V_W-1:0]   vmem_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  localparam vmem_t QIF_THRESH  = 8'sd50;
  localparam vmem_t QIF_V_RESET = -8'sd20;

  localparam vmem_t V_MAX   = 8'sd127;
  localparam vmem_t V_MIN   = -8'sd128;
  localparam acc_t  ACC_MAX = 10'sd127;
  localparam acc_t  ACC_MIN = -10'sd128;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  function automatic acc_t qif_sext(input vmem_t x);
    return {{(ACC_W-V_W){x[V_W-1]}}, x};
  endfunction

  // Every term fits in ACC_W bits, so only the final sum needs clamping.
  function automatic vmem_t qif_next_v(input vmem_t v, input vmem_t i);
    acc_t v_sh;
    acc_t sum;
    v_sh = qif_sext(v >>> 3);
    sum  = qif_sext(v) + qif_sext(i >>> 2) + v_sh * v_sh;
    if (sum > ACC_MAX) begin
      return V_MAX;
    end
    if (sum < ACC_MIN) begin
      return V_MIN;
    end
    return sum[V_W-1:0];
  endfunction

endpackage

// File: rtl/qif_spike_fifo.sv
// Small synchronous FIFO carrying spiking neuron indices toward the spike router.
// DEPTH must be a power of 2 (>= 2) so the pointers wrap on their own.
module qif_spike_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_pop;
  logic          w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/qif_array_scheduler.sv
// Sweeps one shared QIF update datapath over N_NEURONS virtual neurons per tick,
// queueing spiking neuron indices for the downstream spike router.
module qif_array_scheduler
  import qif_pkg::*;
#(
  parameter int    N_NEURONS  = 8,
  parameter vmem_t THRESH     = QIF_THRESH,
  parameter vmem_t V_RESET    = QIF_V_RESET,
  parameter int    FIFO_DEPTH = 4,
  localparam int   IDX_W      = $clog2(N_NEURONS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_tick,
  input  logic              i_isyn_we,
  input  logic [IDX_W-1:0]  i_isyn_addr,
  input  logic [V_W-1:0]    i_isyn_data,
  input  logic [IDX_W-1:0]  i_rd_addr,
  output logic [V_W-1:0]    o_rd_vmem,
  output logic              o_busy,
  output logic              o_sweep_done,
  output logic              o_tick_overrun,
  output logic              o_spike_valid,
  output logic [IDX_W-1:0]  o_spike_id,
  input  logic              i_spike_ready
);

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  vmem_t            r_v;
  vmem_t            r_i;
  vmem_t            r_vmem [N_NEURONS];
  vmem_t            r_isyn [N_NEURONS];
  logic             r_sweep_done;
  logic             r_tick_overrun;

  logic  w_spike;
  logic  w_last;
  logic  w_fifo_full;
  logic  w_fifo_empty;
  logic  w_pop;
  logic  w_stall;
  logic  w_commit;
  logic  w_push;
  vmem_t w_next_v;

  assign w_spike  = (r_v >= THRESH);
  assign w_next_v = qif_next_v(r_v, r_i);
  assign w_last   = (r_idx == IDX_W'(N_NEURONS-1));
  assign w_pop    = i_spike_ready && !w_fifo_empty;
  // A spike with nowhere to go holds WRITE: no commit, no index advance.
  assign w_stall  = (r_state == ST_WRITE) && w_spike && w_fifo_full && !w_pop;
  assign w_commit = (r_state == ST_WRITE) && !w_stall;
  assign w_push   = w_commit && w_spike;

  assign o_rd_vmem      = r_vmem[i_rd_addr];
  assign o_busy         = (r_state != ST_IDLE);
  assign o_sweep_done   = r_sweep_done;
  assign o_tick_overrun = r_tick_overrun;
  assign o_spike_valid  = !w_fifo_empty;

  qif_spike_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (IDX_W)
  ) u_spike_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (r_idx),
    .i_pop   (i_spike_ready),
    .o_data  (o_spike_id),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        r_isyn[k] <= '0;
      end
    end else if (i_isyn_we) begin
      r_isyn[i_isyn_addr] <= i_isyn_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        r_vmem[k] <= '0;
      end
    end else if (w_commit) begin
      r_vmem[r_idx] <= w_spike ? V_RESET : w_next_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_idx          <= '0;
      r_v            <= '0;
      r_i            <= '0;
      r_sweep_done   <= 1'b0;
      r_tick_overrun <= 1'b0;
    end else begin
      r_sweep_done <= w_commit && w_last;
      if (i_tick && (r_state != ST_IDLE)) begin
        r_tick_overrun <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_tick) begin
            r_idx   <= '0;
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          r_v     <= r_vmem[r_idx];
          r_i     <= r_isyn[r_idx];
          r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          if (w_commit) begin
            if (w_last) begin
              r_state <= ST_IDLE;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= ST_FETCH;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qif_array_scheduler.sv
// Directed bench for qif_array_scheduler: hand-computed membrane values, spike ids
// scoreboarded through queues drained by monitors on the valid/ready handshake.
module tb_qif_array_scheduler;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              tick = 1'b0;
  logic              isynWe = 1'b0;
  logic [2:0]        isynAddr = '0;
  logic [7:0]        isynData = '0;
  logic [2:0]        rdAddr = '0;
  logic signed [7:0] rdVmem;
  logic              busy;
  logic              sweepDone;
  logic              tickOverrun;
  logic              spikeValid;
  logic [2:0]        spikeId;
  logic              spikeReady = 1'b0;

  logic              tick2 = 1'b0;
  logic              isynWe2 = 1'b0;
  logic [2:0]        isynAddr2 = '0;
  logic [7:0]        isynData2 = '0;
  logic [2:0]        rdAddr2 = '0;
  logic signed [7:0] rdVmem2;
  logic              busy2;
  logic              sweepDone2;
  logic              tickOverrun2;
  logic              spikeValid2;
  logic [2:0]        spikeId2;
  logic              spikeReady2 = 1'b1;

  int vectors = 0;
  int miscompares = 0;
  int expQ[$];
  int expQ2[$];
  int monExp;
  int monExp2;

  always #5 clk = ~clk;

  qif_array_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_tick         (tick),
    .i_isyn_we      (isynWe),
    .i_isyn_addr    (isynAddr),
    .i_isyn_data    (isynData),
    .i_rd_addr      (rdAddr),
    .o_rd_vmem      (rdVmem),
    .o_busy         (busy),
    .o_sweep_done   (sweepDone),
    .o_tick_overrun (tickOverrun),
    .o_spike_valid  (spikeValid),
    .o_spike_id     (spikeId),
    .i_spike_ready  (spikeReady)
  );

  qif_array_scheduler #(.THRESH(8'sd127)) dutSat (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_tick         (tick2),
    .i_isyn_we      (isynWe2),
    .i_isyn_addr    (isynAddr2),
    .i_isyn_data    (isynData2),
    .i_rd_addr      (rdAddr2),
    .o_rd_vmem      (rdVmem2),
    .o_busy         (busy2),
    .o_sweep_done   (sweepDone2),
    .o_tick_overrun (tickOverrun2),
    .o_spike_valid  (spikeValid2),
    .o_spike_id     (spikeId2),
    .i_spike_ready  (spikeReady2)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Spike monitors pop the expected id whenever the consumer takes the head.
  always @(negedge clk) begin
    if (rst_n && spikeValid && spikeReady) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL spike_unexpected: got id %0d, expected none", spikeId);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("spike_id", int'(spikeId), monExp);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && spikeValid2 && spikeReady2) begin
      if (expQ2.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL spike_unexpected_sat: got id %0d, expected none", spikeId2);
      end else begin
        monExp2 = expQ2.pop_front();
        checkOutput("spike_id_sat", int'(spikeId2), monExp2);
      end
    end
  end

  task automatic checkV(input bit sel, input int idx, input int expV, input string name);
    int actual;
    if (sel) rdAddr2 = 3'(idx);
    else     rdAddr  = 3'(idx);
    #1;
    actual = sel ? int'(rdVmem2) : int'(rdVmem);
    checkOutput(name, actual, expV);
  endtask

  task automatic writeIsyn(input bit sel, input int addr, input int data);
    @(posedge clk); #1;
    if (sel) begin
      isynWe2 = 1'b1; isynAddr2 = 3'(addr); isynData2 = 8'(data);
    end else begin
      isynWe = 1'b1; isynAddr = 3'(addr); isynData = 8'(data);
    end
    @(posedge clk); #1;
    isynWe  = 1'b0;
    isynWe2 = 1'b0;
  endtask

  // Cycles are counted from the edge that accepts the tick (first FETCH).
  task automatic applyStimulus(input bit sel, output int cycles);
    bit done;
    @(posedge clk); #1;
    if (sel) tick2 = 1'b1;
    else     tick  = 1'b1;
    @(posedge clk); #1;
    tick  = 1'b0;
    tick2 = 1'b0;
    cycles = 0;
    done = sel ? sweepDone2 : sweepDone;
    while (!done && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
      done = sel ? sweepDone2 : sweepDone;
    end
    checkOutput("sweep_done_seen", int'(done), 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  cyc;
    int  prevV;
    int  curV;
    bit  sawDone;
    int  expA[4];
    expA = '{10, 21, 35, 61};

    #2;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_sweep_done", int'(sweepDone), 0);
    checkOutput("reset_overrun", int'(tickOverrun), 0);
    checkOutput("reset_spike_valid", int'(spikeValid), 0);
    checkOutput("reset_spike_id", int'(spikeId), 0);
    for (int k = 0; k < 8; k++) checkV(0, k, 0, "reset_vmem");
    #3;
    rst_n = 1'b1;

    // Neuron 0 ramps up under I = 40 and spikes on the fifth sweep.
    spikeReady = 1'b1;
    writeIsyn(0, 0, 40);
    for (int s = 0; s < 4; s++) begin
      applyStimulus(0, cyc);
      checkOutput("sweep_latency", cyc, 16);
      checkV(0, 0, expA[s], "vmem0_ramp");
    end
    expQ.push_back(0);
    applyStimulus(0, cyc);
    checkV(0, 0, -20, "vmem0_spike_reset");
    for (int k = 1; k < 8; k++) checkV(0, k, 0, "vmem_quiet_neuron");

    // Negative membrane with I = 0 exercises the floor shift.
    writeIsyn(0, 0, 0);
    applyStimulus(0, cyc);
    checkV(0, 0, -11, "vmem0_neg_1");
    applyStimulus(0, cyc);
    checkV(0, 0, -7, "vmem0_neg_2");

    // isyn write to neuron 3 lands in the same cycle as its FETCH.
    @(posedge clk); #1;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    isynWe = 1'b1; isynAddr = 3'd3; isynData = 8'd100;
    @(posedge clk); #1;
    isynWe = 1'b0;
    checkOutput("busy_mid_sweep", int'(busy), 1);
    cyc = 0;
    while (!sweepDone && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("sweep_done_seen", int'(sweepDone), 1);
    checkV(0, 3, 0, "collision_old_isyn");
    checkV(0, 0, -6, "vmem0_neg_3");
    applyStimulus(0, cyc);
    checkV(0, 3, 25, "collision_new_isyn");
    checkV(0, 0, -5, "vmem0_neg_4");

    // Tick during a sweep: ignored for sequencing, sticky overrun flag.
    checkOutput("overrun_before", int'(tickOverrun), 0);
    @(posedge clk); #1;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    cyc = 0;
    while (!sweepDone && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      tick = (cyc == 3);
    end
    tick = 1'b0;
    checkOutput("overrun_sweep_latency", cyc, 16);
    checkOutput("overrun_set", int'(tickOverrun), 1);
    checkV(0, 3, 59, "vmem3_after_overrun");
    checkV(0, 0, -4, "vmem0_neg_5");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("no_extra_sweep", int'(busy), 0);
    checkOutput("overrun_sticky", int'(tickOverrun), 1);

    spikeReady = 1'b0;
    applyStimulus(0, cyc);
    checkV(0, 3, -20, "vmem3_spike_reset");
    checkV(0, 0, -3, "vmem0_neg_6");
    checkOutput("spike_pending_valid", int'(spikeValid), 1);
    checkOutput("spike_pending_id", int'(spikeId), 3);

    // Asynchronous reset in the middle of a sweep.
    @(posedge clk); #1;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_busy", int'(busy), 0);
    checkOutput("async_reset_valid", int'(spikeValid), 0);
    checkOutput("async_reset_overrun", int'(tickOverrun), 0);
    checkOutput("async_reset_done", int'(sweepDone), 0);
    checkOutput("async_reset_id", int'(spikeId), 0);
    for (int k = 0; k < 8; k++) checkV(0, k, 0, "async_reset_vmem");
    #2;
    rst_n = 1'b1;
    spikeReady = 1'b1;
    applyStimulus(0, cyc);
    checkV(0, 3, 0, "isyn_cleared_by_reset");
    checkV(0, 0, 0, "vmem0_after_reset");

    // FIFO backpressure: all neurons spike with the consumer stalled.
    for (int k = 0; k < 8; k++) writeIsyn(0, k, 40);
    spikeReady = 1'b0;
    for (int s = 0; s < 4; s++) applyStimulus(0, cyc);
    for (int k = 0; k < 8; k++) checkV(0, k, 61, "stall_precharge");
    for (int k = 0; k < 8; k++) expQ.push_back(k);
    @(posedge clk); #1;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    sawDone = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (sweepDone) sawDone = 1'b1;
    end
    checkOutput("stall_busy", int'(busy), 1);
    checkOutput("stall_no_done", int'(sawDone), 0);
    checkOutput("stall_valid", int'(spikeValid), 1);
    checkOutput("stall_head_id", int'(spikeId), 0);
    checkV(0, 3, -20, "stall_v3_committed");
    checkV(0, 4, 61, "stall_v4_held");
    rdAddr = 3'd7;
    @(posedge clk); #1;
    spikeReady = 1'b1;
    cyc = 0;
    prevV = int'(rdVmem);
    while (!sweepDone && cyc < 100) begin
      prevV = int'(rdVmem);
      @(posedge clk); #1;
      cyc++;
    end
    curV = int'(rdVmem);
    checkOutput("stall_sweep_done_seen", int'(sweepDone), 1);
    checkOutput("v7_before_done", prevV, 61);
    checkOutput("v7_at_done", curV, -20);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("spike_queue_drained", expQ.size(), 0);
    checkOutput("fifo_empty_after_drain", int'(spikeValid), 0);

    // THRESH = 127 instance: reach 120, saturate 376 to 127, then spike.
    writeIsyn(1, 0, 127);
    applyStimulus(1, cyc);
    checkV(1, 0, 31, "sat_step_1");
    applyStimulus(1, cyc);
    checkV(1, 0, 71, "sat_step_2");
    writeIsyn(1, 0, -60);
    applyStimulus(1, cyc);
    checkV(1, 0, 120, "sat_step_3");
    writeIsyn(1, 0, 127);
    applyStimulus(1, cyc);
    checkV(1, 0, 127, "sat_clamp_376");
    expQ2.push_back(0);
    applyStimulus(1, cyc);
    checkV(1, 0, -20, "sat_spike_reset");
    checkV(1, 1, 0, "sat_quiet_neuron");
    repeat (5) @(posedge clk);
    #1;
    checkOutput("sat_spike_queue_drained", expQ2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
